// File: rtl/baugh_wooley_pkg.sv
// Shared types and helpers for the sequential Baugh-Wooley multiplier.
// State encoding and the preload constant K live here so top and bench stay consistent.
package baugh_wooley_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bw_state_t;

    // Upper bound on WIDTH supported by the K helper's fixed return width.
    localparam int BW_MAX_WIDTH = 64;

    // K folds the constant terms of the signed Baugh-Wooley expansion into the preload.
    function automatic logic [2*BW_MAX_WIDTH-1:0] bw_k(input int width, input logic is_signed);
        logic [2*BW_MAX_WIDTH-1:0] k;
        k = '0;
        if (is_signed) begin
            k[width]       = 1'b1;
            k[2*width-1]   = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/bw_row_gen.sv
// Combinational partial-product row for one multiplier bit, already shifted into
// its product columns, with Baugh-Wooley inversions applied in signed mode.
module bw_row_gen
    import baugh_wooley_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               b_bit,
    input  logic [CW-1:0]      row_idx,
    input  logic               is_signed,
    input  logic               last_row,
    output logic [2*WIDTH-1:0] row
);

    logic [WIDTH-1:0] bits;

    // Ordinary rows invert only the MSB term; the last row inverts all but the MSB term.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign bits[gi] = (a[gi] & b_bit) ^ (is_signed & ~last_row);
            end else begin : g_low
                assign bits[gi] = (a[gi] & b_bit) ^ (is_signed & last_row);
            end
        end
    endgenerate

    assign row = {{WIDTH{1'b0}}, bits} << row_idx;

endmodule

// File: rtl/baugh_wooley_seq.sv
// Sequential signed/unsigned multiplier, one partial-product row per clock.
// Optional multiply-accumulate mode is enabled by defining BW_ACC_EN (adds acc_clr).
module baugh_wooley_seq
    import baugh_wooley_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef BW_ACC_EN
    input  logic               acc_clr,
`endif
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    bw_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;

    logic [PW-1:0]             row;
    logic                      last_row;
    logic [2*BW_MAX_WIDTH-1:0] k_full;
    logic [PW-1:0]             k_val;
    logic [PW-1:0]             preload_base;

    assign last_row = (cnt_q == CW'(WIDTH - 1));

    bw_row_gen #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_row_gen (
        .a         (a_q),
        .b_bit     (b_q[cnt_q]),
        .row_idx   (cnt_q),
        .is_signed (sgn_q),
        .last_row  (last_row),
        .row       (row)
    );

    always_comb begin
        k_full = bw_k(WIDTH, is_signed);
        k_val  = k_full[PW-1:0];
`ifdef BW_ACC_EN
        preload_base = acc_clr ? '0 : acc_q;
`else
        preload_base = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    cnt_d   = '0;
                    acc_d   = preload_base + k_val;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + row;
                cnt_d = cnt_q + CW'(1);
                if (last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign prod      = acc_q;

endmodule
